// File: rtl/ddr_arbiter.sv
// Arbitrates the single DDR controller between the display fetch client (priority) and the
// drawing client, masks the controller init period and issues auto-refresh from a credit pool.
module ddr_arbiter #(
  parameter int INIT_WAIT        = 26830,
  parameter int REFRESH_INTERVAL = 1000,
  parameter int REFRESH_WAIT     = 13,
  parameter int MAX_PENDING      = 8,
  parameter int MAX_SKIP         = 4
) (
  input  logic        clk133_p,
  input  logic        rst,
  input  logic        disp_req,
  input  logic [23:0] disp_addr,
  output logic        disp_ack,
  output logic [15:0] disp_rdata,
  input  logic        draw_req,
  input  logic        draw_we,
  input  logic [23:0] draw_addr,
  input  logic [15:0] draw_wdata,
  output logic        draw_ack,
  output logic [15:0] draw_rdata,
  output logic        ddr_read,
  output logic        ddr_write,
  output logic [23:0] ddr_addr,
  output logic [15:0] ddr_wdata,
  output logic        ddr_refresh,
  input  logic        ddr_read_ack,
  input  logic        ddr_write_ack,
  input  logic [15:0] ddr_rdata,
  output logic        refresh_overrun
);
  localparam int CNT_W = $clog2(INIT_WAIT + REFRESH_WAIT + 1);
  localparam int TMR_W = $clog2(REFRESH_INTERVAL + 1);
  localparam int CRD_W = $clog2(MAX_PENDING + 1);
  localparam int SKP_W = $clog2(MAX_SKIP + 1);

  typedef enum logic [2:0] {
    S_INIT = 3'd0, S_IDLE = 3'd1, S_REFRESH = 3'd2, S_RWAIT = 3'd3, S_GRANT = 3'd4, S_GAP = 3'd5
  } state_e;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_DISP = 2'd1, OWN_DRAW = 2'd2} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [CRD_W-1:0]  credits_q, credits_d;
  logic [SKP_W-1:0]  skip_q, skip_d;
  logic              we_q, we_d;
  logic [23:0]       addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       disp_rdata_q, disp_rdata_d;
  logic [15:0]       draw_rdata_q, draw_rdata_d;
  logic              overrun_q, overrun_d;
  logic              refresh_q, disp_ack_q, draw_ack_q;
  logic              credit_add_s, credit_use_s, ack_hit_s;

  // State register and registered client/refresh outputs
  always_ff @(negedge clk133_p or negedge rst) begin
    if (!rst) begin
      state_q      <= S_INIT;
      owner_q      <= OWN_NONE;
      cnt_q        <= {CNT_W{1'b0}};
      tmr_q        <= {TMR_W{1'b0}};
      credits_q    <= {CRD_W{1'b0}};
      skip_q       <= {SKP_W{1'b0}};
      we_q         <= 1'b0;
      addr_q       <= 24'h000000;
      wdata_q      <= 16'h0000;
      disp_rdata_q <= 16'h0000;
      draw_rdata_q <= 16'h0000;
      overrun_q    <= 1'b0;
      refresh_q    <= 1'b0;
      disp_ack_q   <= 1'b0;
      draw_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      tmr_q        <= tmr_d;
      credits_q    <= credits_d;
      skip_q       <= skip_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      disp_rdata_q <= disp_rdata_d;
      draw_rdata_q <= draw_rdata_d;
      overrun_q    <= overrun_d;
      refresh_q    <= (state_d == S_REFRESH);
      disp_ack_q   <= (state_d == S_GAP) && (owner_d == OWN_DISP);
      draw_ack_q   <= (state_d == S_GAP) && (owner_d == OWN_DRAW);
    end
  end

  // Refresh timer and credit pool; a simultaneous add and consume cancel out
  always_comb begin
    credit_add_s = (state_q != S_INIT) && (tmr_q == TMR_W'(REFRESH_INTERVAL - 1));
    credit_use_s = (state_q == S_REFRESH);
    if ((state_q == S_INIT) || credit_add_s) begin
      tmr_d = {TMR_W{1'b0}};
    end else begin
      tmr_d = tmr_q + TMR_W'(1);
    end
    if (credit_add_s && !credit_use_s && (credits_q != CRD_W'(MAX_PENDING))) begin
      credits_d = credits_q + CRD_W'(1);
    end else if (credit_use_s && !credit_add_s) begin
      credits_d = credits_q - CRD_W'(1);
    end else begin
      credits_d = credits_q;
    end
    overrun_d = overrun_q || (credits_d == CRD_W'(MAX_PENDING));
  end

  // Next-state, grant capture and skip accounting
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    skip_d       = skip_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    disp_rdata_d = disp_rdata_q;
    draw_rdata_d = draw_rdata_q;
    ack_hit_s    = we_q ? ddr_write_ack : ddr_read_ack;
    case (state_q)
      S_INIT: begin
        if (cnt_q == CNT_W'(INIT_WAIT - 1)) begin
          state_d = S_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_IDLE: begin
        if (credits_q != {CRD_W{1'b0}}) begin
          state_d = S_REFRESH;
        end else if (draw_req && ((skip_q == SKP_W'(MAX_SKIP)) || !disp_req)) begin
          state_d = S_GRANT;
          owner_d = OWN_DRAW;
          we_d    = draw_we;
          addr_d  = draw_addr;
          wdata_d = draw_wdata;
          skip_d  = {SKP_W{1'b0}};
        end else if (disp_req) begin
          state_d = S_GRANT;
          owner_d = OWN_DISP;
          we_d    = 1'b0;
          addr_d  = disp_addr;
          skip_d  = draw_req ? (skip_q + SKP_W'(1)) : {SKP_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REFRESH: begin
        state_d = S_RWAIT;
        cnt_d   = {CNT_W{1'b0}};
      end
      S_RWAIT: begin
        if (cnt_q == CNT_W'(REFRESH_WAIT - 1)) begin
          state_d = S_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GRANT: begin
        // an ack for the other direction is ignored; there is no grant timeout
        if (ack_hit_s) begin
          state_d = S_GAP;
          if (!we_q && (owner_q == OWN_DISP)) begin
            disp_rdata_d = ddr_rdata;
          end else if (!we_q && (owner_q == OWN_DRAW)) begin
            draw_rdata_d = ddr_rdata;
          end else begin
            draw_rdata_d = draw_rdata_q;
          end
        end else begin
          state_d = S_GRANT;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = S_INIT;
        owner_d = OWN_NONE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // DDR strobes drop combinationally in the ack cycle so the controller cannot re-issue
  always_comb begin
    ddr_read  = 1'b0;
    ddr_write = 1'b0;
    if (state_q == S_GRANT) begin
      ddr_read  = !we_q && !ddr_read_ack;
      ddr_write = we_q && !ddr_write_ack;
    end else begin
      ddr_read  = 1'b0;
      ddr_write = 1'b0;
    end
  end

  assign ddr_addr        = addr_q;
  assign ddr_wdata       = wdata_q;
  assign ddr_refresh     = refresh_q;
  assign disp_ack        = disp_ack_q;
  assign draw_ack        = draw_ack_q;
  assign disp_rdata      = disp_rdata_q;
  assign draw_rdata      = draw_rdata_q;
  assign refresh_overrun = overrun_q;
endmodule
